// File: rtl/cache_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_read_ctrl
// Brief    : Multi-port round-robin blocking read controller with a
//            direct-mapped one-word-line cache, memory refill and flush.
// Revision : 1.0
// ============================================================================
module cache_read_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int INDEX_W   = 6,
  parameter int NUM_PORTS = 2,
  parameter int PORT_W    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        rd_en,
  input  logic [NUM_PORTS*ADDR_W-1:0] rd_addr,
  output logic [NUM_PORTS-1:0]        rd_grant,
  output logic                        rd_valid,
  output logic [PORT_W-1:0]           rd_port,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        mem_req,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic                        mem_ack,
  input  logic                        mem_done,
  input  logic [DATA_W-1:0]           mem_data,
  input  logic                        flush,
  output logic                        flush_busy,
  output logic [2:0]                  read_state,
  output logic [15:0]                 hit_cnt,
  output logic [15:0]                 miss_cnt
);

  localparam int c_depth = 2 ** INDEX_W;
  localparam int c_tag_w = ADDR_W - INDEX_W;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HIT       = 3'd1,
    ST_MISS_REQ  = 3'd2,
    ST_MISS_WAIT = 3'd3,
    ST_FLUSH     = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next_state;

  logic [c_depth-1:0]   r_valid;
  logic [c_tag_w-1:0]   r_tag_mem  [c_depth];
  logic [DATA_W-1:0]    r_data_mem [c_depth];

  logic [PORT_W-1:0]    r_rr;
  logic                 r_rd_valid;
  logic [PORT_W-1:0]    r_rd_port;
  logic [DATA_W-1:0]    r_rd_data;
  logic [ADDR_W-1:0]    r_miss_addr;
  logic [PORT_W-1:0]    r_miss_port;
  logic                 r_flush_pend;
  logic [INDEX_W-1:0]   r_flush_idx;
  logic [15:0]          r_hit_cnt;
  logic [15:0]          r_miss_cnt;

  logic                 w_found;
  logic [PORT_W-1:0]    w_winner;
  logic [PORT_W-1:0]    w_rr_next;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [NUM_PORTS-1:0] w_onehot;
  logic [INDEX_W-1:0]   w_index;
  logic [c_tag_w-1:0]   w_tag;
  logic                 w_hit;
  logic                 w_idle_like;
  logic                 w_accept;
  logic                 w_flush_start;
  logic                 w_refill;
  logic [INDEX_W-1:0]   w_miss_index;

  function automatic int rot(input int base, input int off);
    return (base + off) % NUM_PORTS;
  endfunction

  // Round-robin search: first requester at or after the pointer wins.
  always_comb begin
    w_found    = 1'b0;
    w_winner   = '0;
    w_sel_addr = '0;
    w_onehot   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_found && rd_en[rot(int'(r_rr), i)]) begin
        w_found                       = 1'b1;
        w_winner                      = PORT_W'(rot(int'(r_rr), i));
        w_sel_addr                    = rd_addr[rot(int'(r_rr), i)*ADDR_W +: ADDR_W];
        w_onehot[rot(int'(r_rr), i)]  = 1'b1;
      end
    end
  end

  assign w_rr_next     = PORT_W'((int'(w_winner) + 1) % NUM_PORTS);
  assign w_index       = w_sel_addr[INDEX_W-1:0];
  assign w_tag         = w_sel_addr[ADDR_W-1:INDEX_W];
  assign w_hit         = r_valid[w_index] && (r_tag_mem[w_index] == w_tag);
  assign w_idle_like   = (r_state == ST_IDLE) || (r_state == ST_HIT);
  // A pending flush blocks new accepts, giving it priority over requests.
  assign w_flush_start = w_idle_like && r_flush_pend;
  assign w_accept      = w_idle_like && !r_flush_pend && w_found;
  assign w_refill      = (r_state == ST_MISS_WAIT) && mem_done;
  assign w_miss_index  = r_miss_addr[INDEX_W-1:0];

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_HIT: begin
        if (w_flush_start)  w_next_state = ST_FLUSH;
        else if (w_accept)  w_next_state = w_hit ? ST_HIT : ST_MISS_REQ;
        else                w_next_state = ST_IDLE;
      end
      ST_MISS_REQ:  if (mem_ack)      w_next_state = ST_MISS_WAIT;
      ST_MISS_WAIT: if (mem_done)     w_next_state = ST_IDLE;
      ST_FLUSH:     if (&r_flush_idx) w_next_state = ST_IDLE;
      default:                        w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid      <= '0;
      r_rr         <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_port    <= '0;
      r_rd_data    <= '0;
      r_miss_addr  <= '0;
      r_miss_port  <= '0;
      r_flush_pend <= 1'b0;
      r_flush_idx  <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_accept) begin
        r_rr <= w_rr_next;
        if (w_hit) begin
          r_rd_valid <= 1'b1;
          r_rd_data  <= r_data_mem[w_index];
          r_rd_port  <= w_winner;
          if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
        end else begin
          r_miss_addr <= w_sel_addr;
          r_miss_port <= w_winner;
          if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
        end
      end
      if (w_refill) begin
        r_valid[w_miss_index] <= 1'b1;
        r_rd_valid            <= 1'b1;
        r_rd_data             <= mem_data;
        r_rd_port             <= r_miss_port;
      end
      // Index wraps to zero after the last line, ready for the next flush.
      if (r_state == ST_FLUSH) begin
        r_valid[r_flush_idx] <= 1'b0;
        r_flush_idx          <= r_flush_idx + 1'b1;
      end
      if (w_flush_start)                     r_flush_pend <= 1'b0;
      else if (flush && r_state != ST_FLUSH) r_flush_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_refill) begin
      r_data_mem[w_miss_index] <= mem_data;
      r_tag_mem[w_miss_index]  <= r_miss_addr[ADDR_W-1:INDEX_W];
    end
  end

  assign rd_grant   = w_accept ? w_onehot : '0;
  assign rd_valid   = r_rd_valid;
  assign rd_port    = r_rd_port;
  assign rd_data    = r_rd_data;
  assign mem_req    = (r_state == ST_MISS_REQ);
  assign mem_addr   = r_miss_addr;
  assign flush_busy = r_flush_pend || (r_state == ST_FLUSH);
  assign read_state = r_state;
  assign hit_cnt    = r_hit_cnt;
  assign miss_cnt   = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cache_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_read_ctrl
// Brief    : Directed scoreboard bench for cache_read_ctrl.
// Revision : 1.0
// ============================================================================
module tb_cache_read_ctrl;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int INDEX_W   = 6;
  localparam int NUM_PORTS = 2;
  localparam int PORT_W    = 1;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NUM_PORTS-1:0]        rd_en;
  logic [NUM_PORTS*ADDR_W-1:0] rd_addr;
  logic [NUM_PORTS-1:0]        rd_grant;
  logic                        rd_valid;
  logic [PORT_W-1:0]           rd_port;
  logic [DATA_W-1:0]           rd_data;
  logic                        mem_req;
  logic [ADDR_W-1:0]           mem_addr;
  logic                        mem_ack;
  logic                        mem_done;
  logic [DATA_W-1:0]           mem_data;
  logic                        flush;
  logic                        flush_busy;
  logic [2:0]                  read_state;
  logic [15:0]                 hit_cnt;
  logic [15:0]                 miss_cnt;

  cache_read_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W),
    .NUM_PORTS(NUM_PORTS), .PORT_W(PORT_W)
  ) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_grant(rd_grant),
    .rd_valid(rd_valid), .rd_port(rd_port), .rd_data(rd_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_done(mem_done), .mem_data(mem_data), .flush(flush),
    .flush_busy(flush_busy), .read_state(read_state),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PORT_W-1:0] port;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int p, input logic [DATA_W-1:0] d);
    exp_t e;
    e.port = PORT_W'(p);
    e.data = d;
    sb.push_back(e);
  endtask

  // Monitor: every response pulse is matched against the oldest expectation.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rd_valid: actual port=%0d data=0x%0h required=no response",
                   rd_port, rd_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rd_port", 32'(rd_port), 32'(e.port));
          chk("rd_data", rd_data, e.data);
        end
      end
    end
  endtask

  task automatic issue(input int p, input logic [ADDR_W-1:0] a, input logic [NUM_PORTS-1:0] g);
    @(posedge clk); #1;
    rd_en    = '0;
    rd_en[p] = 1'b1;
    rd_addr[p*ADDR_W +: ADDR_W] = a;
    @(negedge clk);
    chk("rd_grant", 32'(rd_grant), 32'(g));
  endtask

  task automatic hit(input int p, input logic [ADDR_W-1:0] a, input logic [NUM_PORTS-1:0] g,
                     input logic [DATA_W-1:0] d);
    issue(p, a, g);
    push_exp(p, d);
    @(posedge clk); #1;
    rd_en = '0;
    @(negedge clk);
    chk("state_hit", 32'(read_state), 32'd1);
  endtask

  task automatic refill(input int p, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input bit do_flush);
    @(posedge clk); #1;
    rd_en = '0;
    @(negedge clk);
    chk("state_miss_req", 32'(read_state), 32'd2);
    chk("mem_req_high", 32'(mem_req), 32'd1);
    chk("mem_addr", 32'(mem_addr), 32'(a));
    @(posedge clk); #1 mem_ack = 1'b1;
    @(posedge clk); #1 mem_ack = 1'b0;
    if (do_flush) begin
      flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
    end
    @(negedge clk);
    chk("state_miss_wait", 32'(read_state), 32'd3);
    chk("mem_req_low", 32'(mem_req), 32'd0);
    if (do_flush) chk("flush_busy_pending", 32'(flush_busy), 32'd1);
    @(posedge clk); #1;
    mem_done = 1'b1;
    mem_data = d;
    push_exp(p, d);
    @(posedge clk); #1;
    mem_done = 1'b0;
    mem_data = '0;
  endtask

  initial begin
    int n_flush;
    int n_bad;
    rst      = 1'b0;
    rd_en    = '0;
    rd_addr  = '0;
    mem_ack  = 1'b0;
    mem_done = 1'b0;
    mem_data = '0;
    flush    = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(read_state), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_flush_busy", 32'(flush_busy), 32'd0);
    chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Cold miss and refill
    issue(0, 16'h0005, 2'b01);
    refill(0, 16'h0005, 32'hCAFE0005, 1'b0);
    @(negedge clk);
    chk("miss_cnt_1", 32'(miss_cnt), 32'd1);

    // Hits from each port; port1 hit moves the pointer back to port0
    hit(0, 16'h0005, 2'b01, 32'hCAFE0005);
    chk("hit_cnt_1", 32'(hit_cnt), 32'd1);
    hit(1, 16'h0005, 2'b10, 32'hCAFE0005);

    // Both ports requesting: grants alternate, one hit per cycle
    @(posedge clk); #1;
    rd_addr = {16'h0005, 16'h0005};
    rd_en   = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_grant", 32'(rd_grant), (k % 2 == 0) ? 32'd1 : 32'd2);
      push_exp(k % 2, 32'hCAFE0005);
      @(posedge clk); #1;
    end
    rd_en = '0;
    @(negedge clk);
    chk("hit_cnt_6", 32'(hit_cnt), 32'd6);

    // Alias on index 5
    issue(0, 16'h0045, 2'b01);
    refill(0, 16'h0045, 32'h11110045, 1'b0);
    issue(0, 16'h0005, 2'b01);
    refill(0, 16'h0005, 32'hCAFE0005, 1'b0);
    @(negedge clk);
    chk("miss_cnt_3", 32'(miss_cnt), 32'd3);

    // Flush raised during a refill wait
    issue(0, 16'h0045, 2'b01);
    refill(0, 16'h0045, 32'h11110045, 1'b1);
    rd_addr[ADDR_W +: ADDR_W] = 16'h0045;
    rd_en = 2'b10;
    @(negedge clk);
    chk("flush_prio_grant", 32'(rd_grant), 32'd0);
    chk("flush_busy_idle", 32'(flush_busy), 32'd1);
    n_flush = 0;
    n_bad   = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (read_state == 3'd4) begin
        n_flush++;
        if (rd_grant !== 2'b00 || flush_busy !== 1'b1) n_bad++;
      end else begin
        break;
      end
    end
    chk("flush_cycles", 32'(n_flush), 32'd64);
    chk("flush_bad_cycles", 32'(n_bad), 32'd0);
    chk("flush_busy_done", 32'(flush_busy), 32'd0);
    chk("post_flush_grant", 32'(rd_grant), 32'd2);
    refill(1, 16'h0045, 32'h22220045, 1'b0);
    @(negedge clk);
    chk("miss_cnt_5", 32'(miss_cnt), 32'd5);

    // Reset in the middle of a refill wait
    issue(0, 16'h0005, 2'b01);
    @(posedge clk); #1 rd_en = '0;
    @(posedge clk); #1 mem_ack = 1'b1;
    @(posedge clk); #1 mem_ack = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_state", 32'(read_state), 32'd0);
    chk("midrst_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("midrst_miss_cnt", 32'(miss_cnt), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    mem_done = 1'b1;
    mem_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    mem_done = 1'b0;
    mem_data = '0;
    @(negedge clk);
    chk("late_done_state", 32'(read_state), 32'd0);
    issue(0, 16'h0005, 2'b01);
    refill(0, 16'h0005, 32'hCAFE0005, 1'b0);
    @(negedge clk);
    chk("after_rst_miss_cnt", 32'(miss_cnt), 32'd1);
    chk("after_rst_hit_cnt", 32'(hit_cnt), 32'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
